// File: rtl/vmul_lane_sched.sv
// Vector multiply lane scheduler: folds NUMLANES-wide instructions onto NUMMULLANES
// multiplier slices, one active group per cycle, and reassembles the results.
module vmul_lane_sched #(
    parameter int NUMLANES    = 16,
    parameter int NUMMULLANES = 4,
    parameter int WIDTH       = 32,
    parameter int REGIDWIDTH  = 4,
    parameter int MULLAT      = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4:0]                    in_op,
    input  logic [NUMLANES-1:0]           in_mask,
    input  logic [REGIDWIDTH-1:0]         in_dst,
    input  logic                          in_dst_we,
    input  logic [NUMLANES*WIDTH-1:0]     opA,
    input  logic [NUMLANES*WIDTH-1:0]     opB,
    output logic                          mul_valid,
    output logic [4:0]                    mul_op,
    output logic [NUMMULLANES*WIDTH-1:0]  mul_opA,
    output logic [NUMMULLANES*WIDTH-1:0]  mul_opB,
    input  logic [NUMMULLANES*WIDTH-1:0]  mul_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUMLANES*WIDTH-1:0]     result,
    output logic [REGIDWIDTH-1:0]         out_dst,
    output logic                          out_dst_we,
    output logic [NUMLANES-1:0]           out_mask,
    input  logic                          squash,
    output logic                          busy
);

    // state | meaning
    // IDLE  | waiting for an instruction, in_ready high
    // ISSUE | sending one active group per cycle to the multiplier
    // DRAIN | all groups issued, waiting for in-flight results
    // OUT   | result held on the writeback port until out_ready

    localparam int NUMGROUPS = NUMLANES / NUMMULLANES;
    localparam int GIW       = (NUMGROUPS > 1) ? $clog2(NUMGROUPS) : 1;
    localparam int GW        = NUMMULLANES * WIDTH;
    localparam logic [MULLAT-1:0] PIPE_LAST = MULLAT'(1) << (MULLAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

    state_t                            state_q, state_d;
    logic [4:0]                        op_q, hold_op;
    logic [NUMLANES-1:0]               mask_q;
    logic [REGIDWIDTH-1:0]             dst_q;
    logic                              dst_we_q;
    logic [NUMGROUPS-1:0][GW-1:0]      opa_q, opb_q, res_q;
    logic [GW-1:0]                     hold_a, hold_b;
    logic [NUMGROUPS-1:0]              pend_q, pend_after, act_in;
    logic [MULLAT-1:0]                 pipe_v;
    logic [MULLAT-1:0][GIW-1:0]        pipe_g;
    logic [GIW-1:0]                    issue_idx;
    logic                              issuing, accept;

    assign issuing   = (state_q == S_ISSUE);
    assign in_ready  = (state_q == S_IDLE) && !squash;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT) && !squash;
    assign mul_valid = issuing;
    assign mul_op    = issuing ? op_q : hold_op;
    assign mul_opA   = issuing ? opa_q[issue_idx] : hold_a;
    assign mul_opB   = issuing ? opb_q[issue_idx] : hold_b;
    assign result     = res_q;
    assign out_dst    = dst_q;
    assign out_mask   = mask_q;
    assign out_dst_we = dst_we_q && (|mask_q);

    always_comb begin
        act_in = '0;
        for (int g = 0; g < NUMGROUPS; g++) begin
            act_in[g] = |in_mask[g*NUMMULLANES +: NUMMULLANES];
        end
    end

    // Lowest pending group issues next, so skipped groups cost no cycle.
    always_comb begin
        issue_idx = '0;
        for (int g = NUMGROUPS - 1; g >= 0; g--) begin
            if (pend_q[g]) issue_idx = GIW'(g);
        end
        pend_after = pend_q;
        pend_after[issue_idx] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        if (squash) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = (|act_in) ? S_ISSUE : S_OUT;
                S_ISSUE: if (pend_after == '0) state_d = S_DRAIN;
                S_DRAIN: if (pipe_v == PIPE_LAST) state_d = S_OUT;
                S_OUT:   if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= '0;
            mask_q   <= '0;
            dst_q    <= '0;
            dst_we_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            pend_q   <= '0;
            pipe_v   <= '0;
            pipe_g   <= '0;
            hold_op  <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
        end else begin
            if (accept) begin
                op_q     <= in_op;
                mask_q   <= in_mask;
                dst_q    <= in_dst;
                dst_we_q <= in_dst_we;
                opa_q    <= opA;
                opb_q    <= opB;
                res_q    <= '0;
                pend_q   <= act_in;
            end else if (squash) begin
                pend_q <= '0;
            end else if (issuing) begin
                pend_q <= pend_after;
            end

            if (issuing) begin
                hold_op <= op_q;
                hold_a  <= opa_q[issue_idx];
                hold_b  <= opb_q[issue_idx];
            end

            // Stage MULLAT-1 lines up with mul_result of the matching issue.
            if (squash) begin
                pipe_v <= '0;
            end else begin
                for (int s = MULLAT - 1; s > 0; s--) begin
                    pipe_v[s] <= pipe_v[s-1];
                    pipe_g[s] <= pipe_g[s-1];
                end
                pipe_v[0] <= issuing;
                pipe_g[0] <= issue_idx;
                if (pipe_v[MULLAT-1]) res_q[pipe_g[MULLAT-1]] <= mul_result;
            end
        end
    end

endmodule

// File: tb/tb_vmul_lane_sched.sv
// Directed bench for vmul_lane_sched with a 2-cycle lane multiplier model.
module tb_vmul_lane_sched;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid, in_ready;
    logic [4:0]   in_op, mul_op;
    logic [15:0]  in_mask, out_mask;
    logic [3:0]   in_dst, out_dst;
    logic         in_dst_we, out_dst_we;
    logic [511:0] opA, opB, result;
    logic         mul_valid, out_valid, out_ready, squash, busy;
    logic [127:0] mul_opA, mul_opB, mul_result;
    logic [127:0] p1, p2;

    int n_cmp = 0;
    int n_err = 0;
    int n_iss, n_out;
    int iss_n [8];
    logic [127:0] iss_a [8];
    logic [4:0]   iss_op [8];
    logic [511:0] va, vb, exp_r;

    always #5 clk = ~clk;

    vmul_lane_sched dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mask(in_mask),
        .in_dst(in_dst), .in_dst_we(in_dst_we), .opA(opA), .opB(opB),
        .mul_valid(mul_valid), .mul_op(mul_op), .mul_opA(mul_opA), .mul_opB(mul_opB),
        .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_dst(out_dst), .out_dst_we(out_dst_we), .out_mask(out_mask),
        .squash(squash), .busy(busy)
    );

    function automatic logic [127:0] lane_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = a[l*32 +: 32] * b[l*32 +: 32];
        return r;
    endfunction

    // Garbage whenever nothing was issued, so stale captures show up.
    always @(posedge clk) begin
        p1 <= mul_valid ? lane_mul(mul_opA, mul_opB) : {4{32'hBAD0_BAD0}};
        p2 <= p1;
    end
    assign mul_result = p2;

    // Call just after a negedge with the DUT idle; returns at the negedge of the first out_valid.
    task automatic do_instr(input logic [4:0] op, input logic [15:0] mask, input logic [3:0] dst,
                            input logic we, input logic [511:0] a, input logic [511:0] b);
        in_op = op; in_mask = mask; in_dst = dst; in_dst_we = we; opA = a; opB = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_iss = 0;
        n_out = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mul_valid && n_iss < 8) begin
                iss_n[n_iss] = n; iss_a[n_iss] = mul_opA; iss_op[n_iss] = mul_op;
                n_iss++;
            end
            if (out_valid) begin
                n_out = n;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, mul_valid, out_valid, busy, out_dst_we} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 10000", {in_ready, mul_valid, out_valid, busy, out_dst_we});
        end
        n_cmp++;
        if ((result | {mul_opA, mul_opB} | {out_mask, out_dst, mul_op}) !== '0) begin
            n_err++;
            $display("FAIL reset_data: result=%h mask=%h dst=%h mul_op=%h", result, out_mask, out_dst, mul_op);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_mask();
        for (int i = 0; i < 16; i++) begin
            va[i*32 +: 32] = i; vb[i*32 +: 32] = 3; exp_r[i*32 +: 32] = 3 * i;
        end
        do_instr(5'h03, 16'hFFFF, 4'h5, 1'b1, va, vb);
        n_cmp++;
        if (n_iss !== 4) begin n_err++; $display("FAIL full_issue_count: got %0d want 4", n_iss); end
        for (int k = 0; k < 4 && k < n_iss; k++) begin
            n_cmp++;
            if (iss_n[k] !== k + 1 || iss_a[k] !== va[k*128 +: 128] || iss_op[k] !== 5'h03) begin
                n_err++;
                $display("FAIL full_issue%0d: cycle %0d opA %h op %h want cycle %0d opA %h op 03",
                         k, iss_n[k], iss_a[k], iss_op[k], k + 1, va[k*128 +: 128]);
            end
        end
        n_cmp++;
        if (n_out !== 7) begin n_err++; $display("FAIL full_latency: got %0d want 7", n_out); end
        n_cmp++;
        if (result !== exp_r) begin n_err++; $display("FAIL full_result: got %h want %h", result, exp_r); end
        n_cmp++;
        if ({out_mask, out_dst, out_dst_we, in_ready} !== {16'hFFFF, 4'h5, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL full_meta: mask %h dst %h we %b in_ready %b want ffff 5 1 0",
                     out_mask, out_dst, out_dst_we, in_ready);
        end
        n_cmp++;
        if (mul_valid !== 1'b0 || mul_opA !== va[3*128 +: 128] || mul_opB !== vb[3*128 +: 128]) begin
            n_err++;
            $display("FAIL full_mul_hold: valid %b opA %h want 0 %h", mul_valid, mul_opA, va[3*128 +: 128]);
        end
        handshake();
        n_cmp++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_err++; $display("FAIL full_return_idle: got %b want 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_sparse_mask();
        for (int i = 0; i < 16; i++) begin
            va[i*32 +: 32] = 100 + i; vb[i*32 +: 32] = 7;
            exp_r[i*32 +: 32] = (i >= 8 && i < 12) ? 7 * (100 + i) : 0;
        end
        do_instr(5'h11, 16'h0F00, 4'h9, 1'b1, va, vb);
        n_cmp++;
        if (n_iss !== 1 || iss_n[0] !== 1 || iss_a[0] !== va[2*128 +: 128]) begin
            n_err++;
            $display("FAIL sparse_issue: count %0d cycle %0d opA %h want 1 1 %h", n_iss, iss_n[0], iss_a[0], va[2*128 +: 128]);
        end
        n_cmp++;
        if (n_out !== 4) begin n_err++; $display("FAIL sparse_latency: got %0d want 4", n_out); end
        n_cmp++;
        if (result !== exp_r || out_mask !== 16'h0F00 || out_dst_we !== 1'b1) begin
            n_err++;
            $display("FAIL sparse_result: got %h mask %h we %b want %h 0f00 1", result, out_mask, out_dst_we, exp_r);
        end
        handshake();
    endtask

    task automatic test_edge_groups();
        // Only lanes 0 and 15 enabled; unmasked lanes of active groups keep the product.
        for (int i = 0; i < 16; i++) begin
            va[i*32 +: 32] = 2 * i + 1; vb[i*32 +: 32] = 11;
            exp_r[i*32 +: 32] = (i < 4 || i >= 12) ? 11 * (2 * i + 1) : 0;
        end
        do_instr(5'h02, 16'h8001, 4'h3, 1'b0, va, vb);
        n_cmp++;
        if (n_iss !== 2 || iss_n[0] !== 1 || iss_n[1] !== 2 || iss_a[1] !== va[3*128 +: 128]) begin
            n_err++;
            $display("FAIL edge_issue: count %0d cycles %0d,%0d opA %h want 2 1,2 %h",
                     n_iss, iss_n[0], iss_n[1], iss_a[1], va[3*128 +: 128]);
        end
        n_cmp++;
        if (n_out !== 5 || result !== exp_r || out_dst_we !== 1'b0) begin
            n_err++;
            $display("FAIL edge_result: lat %0d we %b got %h want 5 0 %h", n_out, out_dst_we, result, exp_r);
        end
        handshake();
    endtask

    task automatic test_zero_mask();
        for (int i = 0; i < 16; i++) begin va[i*32 +: 32] = i + 9; vb[i*32 +: 32] = 4; end
        do_instr(5'h05, 16'h0000, 4'hA, 1'b1, va, vb);
        n_cmp++;
        if (n_iss !== 0 || n_out !== 1) begin
            n_err++; $display("FAIL zero_timing: issues %0d latency %0d want 0 1", n_iss, n_out);
        end
        n_cmp++;
        if (result !== '0 || out_dst_we !== 1'b0 || out_mask !== 16'h0 || out_dst !== 4'hA) begin
            n_err++;
            $display("FAIL zero_result: result %h we %b mask %h dst %h want 0 0 0 a", result, out_dst_we, out_mask, out_dst);
        end
        handshake();
    endtask

    task automatic test_out_stall();
        for (int i = 0; i < 16; i++) begin
            va[i*32 +: 32] = 3 * i; vb[i*32 +: 32] = i; exp_r[i*32 +: 32] = 3 * i * i;
        end
        do_instr(5'h07, 16'hFFFF, 4'hC, 1'b1, va, vb);
        n_cmp++;
        if (n_out !== 7) begin n_err++; $display("FAIL stall_latency: got %0d want 7", n_out); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_r || out_dst !== 4'hC || out_mask !== 16'hFFFF) begin
                n_err++;
                $display("FAIL stall_hold%0d: valid %b in_ready %b dst %h result %h want 1 0 c %h",
                         c, out_valid, in_ready, out_dst, result, exp_r);
            end
        end
        handshake();
        n_cmp++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_err++; $display("FAIL stall_release: got %b want 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_back_to_back();
        do_instr(5'h01, 16'h0000, 4'h1, 1'b0, va, vb);
        for (int i = 0; i < 16; i++) begin va[i*32 +: 32] = i + 20; vb[i*32 +: 32] = 2; end
        in_op = 5'h04; in_mask = 16'h00F0; in_dst = 4'h6; in_dst_we = 1'b1; opA = va; opB = vb;
        in_valid = 1'b1; out_ready = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_out_cycle: in_ready %b out_valid %b want 0 1", in_ready, out_valid);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_err++; $display("FAIL b2b_no_accept: got %b want 100", {in_ready, busy, out_valid});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || mul_valid !== 1'b1 || mul_opA !== va[1*128 +: 128] || mul_op !== 5'h04) begin
            n_err++;
            $display("FAIL b2b_issue: busy %b valid %b opA %h op %h want 1 1 %h 04", busy, mul_valid, mul_opA, mul_op, va[1*128 +: 128]);
        end
        n_out = -1;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin n_out = n; break; end
        end
        for (int i = 0; i < 16; i++) exp_r[i*32 +: 32] = (i >= 4 && i < 8) ? 2 * (i + 20) : 0;
        n_cmp++;
        if (n_out !== 4 || result !== exp_r) begin
            n_err++; $display("FAIL b2b_result: lat %0d got %h want 4 %h", n_out, result, exp_r);
        end
        handshake();
    endtask

    task automatic test_squash();
        for (int i = 0; i < 16; i++) begin va[i*32 +: 32] = i; vb[i*32 +: 32] = 3; end
        in_op = 5'h03; in_mask = 16'hFFFF; in_dst = 4'h2; in_dst_we = 1'b1; opA = va; opB = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mul_valid !== 1'b1 || mul_opA !== va[1*128 +: 128]) begin
            n_err++; $display("FAIL squash_second_issue: valid %b opA %h want 1 %h", mul_valid, mul_opA, va[1*128 +: 128]);
        end
        squash = 1'b1;
        @(posedge clk);
        #1 squash = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, busy, mul_valid, out_valid} !== 4'b1000) begin
            n_err++; $display("FAIL squash_idle: got %b want 1000", {in_ready, busy, mul_valid, out_valid});
        end
        // Immediate follow-up skips group 1 so a stale capture into it would be visible.
        for (int i = 0; i < 16; i++) begin
            va[i*32 +: 32] = i + 1; vb[i*32 +: 32] = 5;
            exp_r[i*32 +: 32] = (i >= 4 && i < 8) ? 0 : 5 * (i + 1);
        end
        do_instr(5'h03, 16'hFF0F, 4'h8, 1'b1, va, vb);
        n_cmp++;
        if (n_iss !== 3 || n_out !== 6) begin
            n_err++; $display("FAIL squash_next_timing: issues %0d latency %0d want 3 6", n_iss, n_out);
        end
        n_cmp++;
        if (result !== exp_r) begin n_err++; $display("FAIL squash_next_result: got %h want %h", result, exp_r); end
        squash = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL squash_out_suppress: got %b want 0", out_valid); end
        @(posedge clk);
        #1 squash = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; squash = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL squash_blocks_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0; squash = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL squash_over_accept: busy %b want 0", busy); end
    endtask

    task automatic test_reset_drain();
        int seen;
        for (int i = 0; i < 16; i++) begin va[i*32 +: 32] = i + 2; vb[i*32 +: 32] = 6; end
        in_op = 5'h09; in_mask = 16'hFFFF; in_dst = 4'hF; in_dst_we = 1'b1; opA = va; opB = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || mul_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_in_drain: busy %b valid %b out %b want 1 0 0", busy, mul_valid, out_valid);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, mul_valid, out_valid, busy, out_dst_we} !== 5'b10000) begin
            n_err++;
            $display("FAIL rst_async_flags: got %b want 10000", {in_ready, mul_valid, out_valid, busy, out_dst_we});
        end
        n_cmp++;
        if ((result | {mul_opA, mul_opB} | {out_mask, out_dst, mul_op}) !== '0) begin
            n_err++;
            $display("FAIL rst_async_data: result %h mask %h dst %h opA %h", result, out_mask, out_dst, mul_opA);
        end
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL rst_no_out: active cycles %0d want 0", seen); end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; squash = 1'b0;
        in_op = '0; in_mask = '0; in_dst = '0; in_dst_we = 1'b0; opA = '0; opB = '0;
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_edge_groups();
        test_zero_mask();
        test_out_stall();
        test_back_to_back();
        test_squash();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vmul_lane_sched.md
VMUL_LANE_SCHED -- requirements
Module: vmul_lane_sched

Interface
REQ-001 SHALL have parameter NUMLANES, default 16, meaning vector lanes per instruction.
REQ-002 SHALL have parameter NUMMULLANES, default 4, meaning physical multiplier slices; NUMLANES SHALL be an integer multiple of NUMMULLANES, with NUMGROUPS = NUMLANES/NUMMULLANES.
REQ-003 SHALL have parameter WIDTH, default 32, meaning element width in bits.
REQ-004 SHALL have parameter REGIDWIDTH, default 4, meaning destination register id width.
REQ-005 SHALL have parameter MULLAT, default 2, meaning fixed multiplier latency in cycles (>=1).
REQ-006 SHALL have ports clk (in, 1, clock) and resetn (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-007 SHALL have in_valid (in, 1), in_ready (out, 1), in_op (in, 5), in_mask (in, NUMLANES), in_dst (in, REGIDWIDTH), in_dst_we (in, 1), opA and opB (in, NUMLANES*WIDTH each): the instruction request.
REQ-008 SHALL have mul_valid (out, 1), mul_op (out, 5), mul_opA and mul_opB (out, NUMMULLANES*WIDTH each), mul_result (in, NUMMULLANES*WIDTH): the shared multiplier interface.
REQ-009 SHALL have out_valid (out, 1), out_ready (in, 1), result (out, NUMLANES*WIDTH), out_dst (out, REGIDWIDTH), out_dst_we (out, 1), out_mask (out, NUMLANES): the writeback.
REQ-010 SHALL have squash (in, 1) to abort the current instruction and busy (out, 1), high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, DRAIN and OUT.
REQ-012 in_ready SHALL be 1 only in IDLE; an accept occurs when in_valid & in_ready at a rising edge, and SHALL latch op, mask, dst, dst_we, opA and opB.
REQ-013 Group g (lanes g*NUMMULLANES .. g*NUMMULLANES+NUMMULLANES-1) SHALL be active iff its latched mask bits are not all zero.
REQ-014 On accept with at least one active group: go to ISSUE; with zero active groups: go directly to OUT.
REQ-015 In ISSUE, exactly one active group per cycle SHALL be issued, in ascending g, with mul_valid=1, mul_op=latched op and mul_opA/mul_opB = that group's slice; inactive groups SHALL be skipped with no cycle spent.
REQ-016 mul_valid SHALL be 0 outside ISSUE, and mul_opA/mul_opB/mul_op SHALL be held at their last values when mul_valid=0.
REQ-017 After the last active group issues, the FSM SHALL go to DRAIN.
REQ-018 A MULLAT-deep valid/group-index pipeline SHALL track in-flight issues; mul_result SHALL be captured into the result slot of the group issued MULLAT cycles earlier.
REQ-019 DRAIN SHALL go to OUT at the edge on which the last in-flight result is captured.
REQ-020 Result slots of inactive groups SHALL be zero, and result lanes of active groups whose mask bit is 0 SHALL keep the multiplier value (out_mask qualifies them).
REQ-021 Latency: with an accept at edge T0 and G active groups, issues occur in cycles T0+1..T0+G and out_valid SHALL first be 1 in cycle T0+G+MULLAT+1; for G=0, out_valid SHALL be 1 in cycle T0+1.
REQ-022 In OUT, out_valid=1 and result/out_dst/out_mask SHALL be stable until out_ready=1; at that edge the FSM SHALL return to IDLE.
REQ-023 out_dst_we SHALL equal latched dst_we AND (|latched mask).
REQ-024 No new accept SHALL occur in the cycle out_valid&out_ready completes; in_ready SHALL rise the following cycle.
REQ-025 squash=1 in any state SHALL move the FSM to IDLE at the next edge, clear the in-flight pipeline and suppress out_valid; late mul_result values SHALL be ignored.
REQ-026 squash SHALL take priority over accept and over the out_ready handshake in the same cycle.
REQ-027 The group index counter SHALL be ceil(log2(NUMGROUPS)) bits, min 1, and SHALL NOT wrap within one instruction.

Reset
REQ-028 While resetn=0: FSM=IDLE, in_ready=1, mul_valid=0, out_valid=0, busy=0, out_dst_we=0, and the in-flight pipeline cleared.
REQ-029 While resetn=0: result, out_mask, out_dst, mul_opA, mul_opB and mul_op SHALL be zero.
REQ-030 Reset asserted mid-instruction SHALL discard the instruction with no out_valid pulse after release.

Verification
REQ-031 Defaults, mask=16'hFFFF, opA lane i=i, opB=3, model mul=A*B latency 2 -> 4 mul_valid cycles T0+1..T0+4, out_valid at T0+7, result lane i=3*i.
REQ-032 mask=16'h0F00 -> single issue (group 2) at T0+1, out_valid at T0+4, lanes 0-7 and 12-15 zero, out_mask=16'h0F00.
REQ-033 mask=16'h0000, in_dst_we=1 -> no mul_valid, out_valid at T0+1, result all zero, out_dst_we=0.
REQ-034 out_ready held 0 for 5 cycles in OUT -> outputs stable and in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-035 squash in the second ISSUE cycle of a full-mask instruction -> IDLE next cycle, no out_valid; next instruction yields correct results unaffected by stale mul_result.
REQ-036 resetn pulsed low in DRAIN -> all outputs per REQ-028/029 immediately (asynchronous), no out_valid afterwards.
